// File: rtl/reaction_timer_core.sv
// reaction_timer_core: reaction-time game controller producing the display number, GO LED and state.
// Buttons are synchronized and debounced, the GO delay comes from an LFSR, and reaction is timed in ms.
module rt_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    logic s1, s2, lvl, lvl_d;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
            // any sample agreeing with the accepted level restarts the stability count
            if (s2 == lvl) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                lvl <= s2;
                cnt <= '0;
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

module reaction_timer_core #(
    parameter int TICK_DIV    = 100_000,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 11,
    parameter int MAX_MS      = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic [15:0] number,
    output logic        led_go,
    output logic        busy,
    output logic [2:0]  state_dbg
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    if (MIN_WAIT_MS + 2**RAND_BITS - 1 >= 65536) begin : g_bad_wait
        $error("reaction_timer_core: wait target does not fit in 16 bits");
    end

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT        = 3'd1,
        GO          = 3'd2,
        DONE        = 3'd3,
        FALSE_START = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic [TW-1:0] tcnt;
    logic [15:0]   wait_ms, wait_ms_n, wait_target, wait_target_n;
    logic [15:0]   react_ms, react_ms_n, number_n;
    logic          start_p, react_p, tick;

    rt_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (.clk(clk), .rst(rst), .raw(start_btn), .press(start_p));
    rt_debounce #(.DB_CYCLES(DB_CYCLES)) u_react_db (.clk(clk), .rst(rst), .raw(react_btn), .press(react_p));

    assign tick      = tcnt == TW'(TICK_DIV - 1);
    assign state_dbg = state;

    always_comb begin
        state_n       = state;
        wait_ms_n     = wait_ms;
        wait_target_n = wait_target;
        react_ms_n    = react_ms;
        number_n      = number;
        case (state)
            IDLE, DONE, FALSE_START: begin
                if (start_p) begin
                    state_n       = WAIT;
                    wait_target_n = 16'(MIN_WAIT_MS) + 16'(lfsr[RAND_BITS-1:0]);
                    wait_ms_n     = '0;
                    react_ms_n    = '0;
                    number_n      = '0;
                end
            end
            WAIT: begin
                if (react_p) begin
                    state_n  = FALSE_START;
                    number_n = 16'hEEEE;
                end else if (tick) begin
                    wait_ms_n = wait_ms + 16'd1;
                    if (wait_ms + 16'd1 >= wait_target) begin
                        state_n    = GO;
                        react_ms_n = '0;
                        number_n   = '0;
                    end
                end
            end
            GO: begin
                // a react pulse beats a coincident tick, so the capture excludes that tick
                if (react_p) begin
                    state_n  = DONE;
                    number_n = react_ms;
                end else if (tick) begin
                    react_ms_n = react_ms + 16'd1 >= 16'(MAX_MS) ? 16'(MAX_MS) : react_ms + 16'd1;
                    number_n   = react_ms_n;
                    state_n    = react_ms + 16'd1 >= 16'(MAX_MS) ? DONE : GO;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= 16'hACE1;
            tcnt        <= '0;
            wait_ms     <= '0;
            wait_target <= '0;
            react_ms    <= '0;
            number      <= '0;
            led_go      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            state       <= state_n;
            tcnt        <= (state_n != state || tick) ? '0 : tcnt + TW'(1);
            wait_ms     <= wait_ms_n;
            wait_target <= wait_target_n;
            react_ms    <= react_ms_n;
            number      <= number_n;
            led_go      <= state_n == GO;
            busy        <= state_n == WAIT || state_n == GO;
        end
    end
endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core: scoreboard bench; stimulus predicts every output change, a monitor checks them.
module tb_reaction_timer_core;
    localparam int TD = 4;
    localparam int MW = 5;
    localparam int RB = 3;
    localparam int MX = 20;
    localparam int PL = 7;

    typedef struct {
        int c;
        int st;
        int num;
        int go;
        int bsy;
    } ev_t;

    logic        clk, rst, start_btn, react_btn;
    logic [15:0] number;
    logic        led_go, busy;
    logic [2:0]  state_dbg;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] hist [0:32767];
    ev_t         q[$];

    reaction_timer_core #(
        .TICK_DIV(TD), .DB_CYCLES(3), .MIN_WAIT_MS(MW), .RAND_BITS(RB), .MAX_MS(MX)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .react_btn(react_btn),
        .number(number), .led_go(led_go), .busy(busy), .state_dbg(state_dbg)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            lfsr_m = rst ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            cyc = cyc + 1;
            hist[cyc] = lfsr_m;
        end
    end

    initial begin
        logic [21:0] prev, cur;
        ev_t ev;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {state_dbg, number, led_go, busy, 1'b0, 1'b0};
            if (mon_en && cur != prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got st=%0d num=%h go=%b busy=%b",
                             cyc, state_dbg, number, led_go, busy);
                end else begin
                    ev = q.pop_front();
                    if (ev.c != cyc || ev.st != int'(state_dbg) || ev.num != int'(number) ||
                        ev.go != int'(led_go) || ev.bsy != int'(busy)) begin
                        errors++;
                        $display("FAIL event got cyc=%0d st=%0d num=%h go=%b busy=%b expected cyc=%0d st=%0d num=%h go=%0d busy=%0d",
                                 cyc, state_dbg, number, led_go, busy, ev.c, ev.st, ev.num, ev.go, ev.bsy);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic push(input int c, input int st, input int num, input int go, input int bsy);
        ev_t ev;
        ev.c = c; ev.st = st; ev.num = num; ev.go = go; ev.bsy = bsy;
        q.push_back(ev);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        if (cyc < t) wait_edges(t - cyc);
        else if (cyc > t) chk("schedule", cyc, t);
    endtask

    // raw press set now is first sampled at the next edge; the FSM reacts PL edges from now
    task automatic press(input logic s, input logic r);
        start_btn = s;
        react_btn = r;
        wait_edges(8);
        start_btn = 0;
        react_btn = 0;
        wait_edges(6);
    endtask

    function automatic int go_edge(input int e);
        logic [15:0] v;
        v = hist[e-1];
        return e + (MW + int'(v & 16'((1 << RB) - 1))) * TD;
    endfunction

    task automatic begin_round(input logic with_react, output int e);
        e = cyc + PL;
        push(e, 1, 0, 0, 1);
        press(1, with_react);
    endtask

    // d < 0: let it time out; otherwise react lands d cycles after GO entry
    task automatic run_go(input int e, input int d);
        int g, n;
        g = go_edge(e);
        push(g, 2, 0, 1, 1);
        if (d < 0) begin
            for (int k = 1; k < MX; k++) push(g + k * TD, 2, k, 1, 1);
            push(g + MX * TD, 3, MX, 0, 0);
            wait_until(g + MX * TD + 1);
        end else begin
            n = (d - 1) / TD;
            for (int k = 1; k <= n; k++) push(g + k * TD, 2, k, 1, 1);
            push(g + d, 3, n, 0, 0);
            wait_until(g + d - PL);
            press(0, 1);
        end
    endtask

    task automatic run_false(input int e, input bit at_go);
        int g, t;
        g = go_edge(e);
        t = at_go ? g : e + 14 + int'($urandom_range(0, 32'(g - e - 15)));
        push(t, 4, 16'hEEEE, 0, 0);
        wait_until(t - PL);
        press(0, 1);
    endtask

    initial begin
        int e, g;
        rst = 1;
        start_btn = 0;
        react_btn = 0;
        wait_edges(2);
        rst = 0;
        chk("reset_number", int'(number), 0);
        chk("reset_led_go", int'(led_go), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_state", int'(state_dbg), 0);
        mon_en = 1;
        wait_edges(200);
        chk("idle_state", int'(state_dbg), 0);
        chk("idle_number", int'(number), 0);

        for (int i = 0; i < 5; i++) begin
            start_btn = 1;
            wait_edges(2);
            start_btn = 0;
            wait_edges(2);
        end
        wait_edges(10);
        chk("chatter_state", int'(state_dbg), 0);

        begin_round(0, e);
        run_go(e, 7 * TD + int'($urandom_range(1, TD - 1)));
        chk("normal_number", int'(number), 7);
        chk("normal_state", int'(state_dbg), 3);

        begin_round(0, e);
        run_false(e, 0);
        chk("false_number", int'(number), 16'hEEEE);
        begin_round(0, e);
        chk("restart_number", int'(number), 0);
        chk("restart_state", int'(state_dbg), 1);
        run_go(e, -1);
        chk("timeout_number", int'(number), MX);

        begin_round(0, e);
        run_go(e, 4 * TD);
        chk("tie_number", int'(number), 3);

        begin_round(1, e);
        run_false(e, 1);
        chk("react_at_target_state", int'(state_dbg), 4);

        for (int i = 0; i < 8; i++) begin
            begin_round(1'($urandom_range(0, 1)), e);
            if ($urandom_range(0, 3) == 0) run_false(e, 0);
            else run_go(e, int'($urandom_range(1, MX * TD - 1)));
        end

        begin_round(0, e);
        g = go_edge(e);
        push(g, 2, 0, 1, 1);
        push(g + TD, 2, 1, 1, 1);
        push(g + 2 * TD, 2, 2, 1, 1);
        wait_until(g + 2 * TD + 2);
        rst = 1;
        push(g + 2 * TD + 3, 0, 0, 0, 0);
        wait_edges(1);
        rst = 0;
        chk("midgo_reset_state", int'(state_dbg), 0);
        chk("midgo_reset_number", int'(number), 0);
        begin_round(0, e);
        run_go(e, int'($urandom_range(1, MX * TD - 1)));

        wait_edges(20);
        chk("events_pending", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Game controller that produces the 16-bit `number` value consumed by the 4-digit seven-segment display driver.
- Conditions the raw start and react buttons, waits a pseudo-random delay, lights the GO LED, then measures reaction time in milliseconds.
- Publishes the result as binary 0..9999, or the 16'hEEEE false-start code that the display shows as "EEEE".

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick (100 MHz clk).
- DB_CYCLES, 1_000_000: consecutive stable synchronized samples needed to accept a button level change (10 ms).
- MIN_WAIT_MS, 1000: fixed part of the random pre-GO delay, in ms.
- RAND_BITS, 11: number of LFSR bits added to the delay (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999: saturation and timeout value for the reaction count.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- start_btn  input  1  raw asynchronous start pushbutton, active high.
- react_btn  input  1  raw asynchronous react pushbutton, active high.
- number  output  16  display value: 0..9999 binary, or 16'hEEEE for false start.
- led_go  output  1  high while in GO.
- busy  output  1  high in WAIT or GO.
- state_dbg  output  3  encoded state: IDLE=0, WAIT=1, GO=2, DONE=3, FALSE_START=4.

Behaviour:
- Reset (sync, rst high at posedge):
  - state=IDLE, number=0, led_go=0, busy=0.
  - LFSR=16'hACE1; all counters, synchronizers and debounce levels cleared to 0.
  - rst asserted mid-game aborts immediately; no pulse or state survives.
- Button path, one per button:
  - 2-flop synchronizer feeds a debounce counter.
  - The debounced level changes only after the synchronized value differs from it for DB_CYCLES consecutive cycles. Any mismatch break clears the counter.
  - A 1-cycle press pulse fires on the debounced 0->1 edge. A stable raw high first sampled at edge k gives a pulse at edge k+DB_CYCLES+2.
  - Releases generate no pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk cycle, never all-zero.
- ms tick:
  - Counter runs 0..TICK_DIV-1; tick is a 1-cycle pulse at terminal count.
  - Counter is cleared on every state transition, so the first tick occurs TICK_DIV cycles after state entry.
- IDLE / DONE / FALSE_START:
  - start pulse -> WAIT.
  - Latch wait_target = MIN_WAIT_MS + LFSR[RAND_BITS-1:0], using the LFSR value in that cycle.
  - Clear wait_ms and react_ms; number=0.
  - react pulses are ignored.
  - number holds its last value: the result in DONE, EEEE in FALSE_START.
- WAIT:
  - wait_ms increments on each tick.
  - react pulse -> FALSE_START, number=16'hEEEE. This has priority over reaching the target in the same cycle.
  - When wait_ms reaches wait_target -> GO, led_go=1, react_ms=0.
  - start pulse is ignored.
- GO:
  - react_ms increments on each tick, saturating at MAX_MS; number mirrors react_ms live.
  - react pulse -> DONE, number=react_ms, led_go=0.
  - If a tick and a react pulse coincide, the react pulse wins and the captured value excludes that tick.
  - When react_ms reaches MAX_MS -> DONE with number=MAX_MS (timeout).
  - start pulse is ignored.
- Simultaneous start and react pulses in IDLE/DONE/FALSE_START: start is taken, react is dropped.
- Width rules:
  - wait_ms and wait_target are 16 bits. MIN_WAIT_MS + 2^RAND_BITS - 1 must be < 65536, checked at elaboration.
  - number never holds values in 10000..65535 except 16'hEEEE.
- All outputs are registered; number/led_go/busy/state_dbg update on the same edge as the state register.

Test Plan (TICK_DIV=4, DB_CYCLES=3, MIN_WAIT_MS=5, RAND_BITS=3, MAX_MS=20; bench mirrors the LFSR):
- Reset: hold rst 2 cycles, then release -> number=0, led_go=0, busy=0, state_dbg=0; with no buttons pressed, outputs stay constant for 200 cycles.
- Debounce:
  - start_btn chattering (toggle every 2 cycles for 20 cycles) -> no transition.
  - Stable high from edge k -> state_dbg=1 at edge k+6.
- Normal round: start, then press react 7 ticks after led_go rises -> number=7, state=DONE, led_go=0, busy=0. The GO entry time must equal (5 + modeled LFSR[2:0]) ms after WAIT entry.
- False start: react pressed during WAIT -> number=16'hEEEE, state=FALSE_START; a later start pulse -> WAIT, number=0.
- Timeout: no react in GO -> number counts 1..20, then DONE with number=20 (0x0014).
- Boundaries:
  - react pulse forced on the same cycle as a GO tick at react_ms=3 -> number=3.
  - start+react pulses in the same cycle from DONE -> WAIT.
  - rst asserted mid-GO -> IDLE with number=0 the next cycle.
